herring_phi2_gen: RTL and testbench
===================================

// Module: herring_phi2_gen
// PURPOSE
// - 6502 PHI2 clock and reset generator. Sits upstream of the address decoder and CPU.
// - Divides clk_src (50 MHz) into PHI2 (default 1 MHz). Stretches the PHI2 high phase
//   when the decoder flags a slow device. Supports run/single-step.
// - Holds CPU RESB low for a fixed number of PHI2 cycles after reset.
// PARAMETERS
// - LOW_TICKS     25  clk_src cycles PHI2 is low per cycle (1..255)
// - HIGH_TICKS    25  clk_src cycles PHI2 is high in a normal cycle (1..255)
// - STRETCH_TICKS 50  extra clk_src cycles of PHI2 high when stretched (1..255)
// - RESET_CYCLES   4  PHI2 falling edges with resb_n held low after rst drops (1..255)
// PORTS
// - clk_src     in   1  50 MHz source clock; all logic is on its posedge
// - rst         in   1  async active-high reset
// - slow_sel_n  in   1  active-low slow-device select from the decoder
// - run         in   1  1 = free-running clock; 0 = park PHI2 low. Synchronous to clk_src.
// - step        in   1  1-clk pulse; while run=0, requests exactly one PHI2 cycle
// - phi2        out  1  registered CPU clock (drives the CPU clock input)
// - resb_n      out  1  registered active-low CPU reset
// - stretching  out  1  1 while in STRETCH state
// - phi2_fall   out  1  1-clk strobe on the clk_src cycle where phi2 goes 1->0
// BEHAVIOUR
// - Reset (async): state=LOW, tick counter=0, phi2=0, resb_n=0, stretching=0,
//   phi2_fall=0, step_pend=0, reset-cycle counter=0.
// - Counters are 8 bits wide. The tick counter counts 0..N-1 within each state and
//   clears on every state change.
// - LOW state (phi2=0):
//   - At tick LOW_TICKS-1, go to HIGH if run=1 or step_pend=1; otherwise park.
//   - Parking holds LOW with the counter frozen at LOW_TICKS-1.
//   - The next cycle with run=1 or step_pend=1 enters HIGH.
// - HIGH state (phi2=1, HIGH_TICKS ticks):
//   - Sample slow_sel_n on tick HIGH_TICKS-1.
//   - If slow_sel_n=0, go to STRETCH (phi2 stays 1, no glitch). Otherwise go to LOW.
// - STRETCH state (phi2=1, stretching=1):
//   - Lasts STRETCH_TICKS ticks, then goes to LOW.
//   - slow_sel_n is ignored here. There is no re-stretch.
// - phi2, stretching and phi2_fall are registered outputs. They change on the same edge
//   as the state register. Cycle periods are therefore exact:
//   - normal cycle = LOW_TICKS + HIGH_TICKS
//   - stretched cycle = LOW_TICKS + HIGH_TICKS + STRETCH_TICKS
// - step handling:
//   - A step pulse with run=0 sets step_pend. step_pend clears on entry to HIGH.
//   - Steps do not queue: a second step before consumption is lost.
//   - step with run=1 is ignored and does not set step_pend.
// - run 1->0 mid-cycle: the current cycle (including any stretch) completes, then
//   the clock parks in LOW.
// - Reset release:
//   - The reset-cycle counter increments on each phi2_fall after rst is deasserted,
//     saturating at RESET_CYCLES.
//   - resb_n goes 1 on the same edge as the RESET_CYCLES-th phi2_fall.
//   - Parked time does not count.
// - rst mid-cycle: phi2 drops to 0 asynchronously and resb_n drops to 0. The sequence
//   restarts from LOW tick 0.
// TESTING
// - Defaults, run=1, slow_sel_n=1 -> phi2 period 50 clk, high 25 / low 25.
//   First rise at clk 25 after rst deassert.
// - Reset release -> resb_n=0 until the 4th phi2_fall; resb_n=1 on that clk, stays 1.
// - slow_sel_n=0 during one HIGH phase -> that cycle's phi2 high=75 clk,
//   stretching=1 for exactly 50 clk, next cycle a normal 50 clk.
// - run=0 -> phi2 parks low after the current cycle. One step pulse -> exactly one
//   25-clk high pulse, then parks again. Two steps 3 clk apart -> one pulse.
// - Assert rst while in STRETCH -> phi2=0, resb_n=0, stretching=0 immediately.
//   After release, a 4-cycle reset sequence runs again.
// - LOW/HIGH/STRETCH=1/1/1, run=1, slow_sel_n=0 -> period 3 clk, no missing or extra
//   phi2_fall strobes.

Source files
------------

// File: rtl/herring_phi2_gen.sv
// 6502 PHI2 clock and CPU reset generator: divides clk_src into PHI2 with optional
// high-phase stretch for slow devices, run/single-step control and a RESB hold-off.
module herring_phi2_gen #(
  parameter int unsigned LOW_TICKS     = 25,
  parameter int unsigned HIGH_TICKS    = 25,
  parameter int unsigned STRETCH_TICKS = 50,
  parameter int unsigned RESET_CYCLES  = 4
) (
  input  logic clk_src,
  input  logic rst,
  input  logic slow_sel_n,
  input  logic run,
  input  logic step,
  output logic phi2,
  output logic resb_n,
  output logic stretching,
  output logic phi2_fall
);

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_HIGH    = 2'd1,
    S_STRETCH = 2'd2
  } state_t;

  localparam logic [7:0] LOW_END  = 8'(LOW_TICKS - 1);
  localparam logic [7:0] HIGH_END = 8'(HIGH_TICKS - 1);
  localparam logic [7:0] STR_END  = 8'(STRETCH_TICKS - 1);
  localparam logic [7:0] RST_END  = 8'(RESET_CYCLES);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] rcnt;
  logic       step_pend;
  logic       fall_now;

  always_comb begin
    fall_now = 1'b0;
    if (state == S_HIGH && cnt == HIGH_END && slow_sel_n)
      fall_now = 1'b1;
    else if (state == S_STRETCH && cnt == STR_END)
      fall_now = 1'b1;
  end

  always_ff @(posedge clk_src or posedge rst) begin
    if (rst) begin
      state      <= S_LOW;
      cnt        <= '0;
      rcnt       <= '0;
      step_pend  <= 1'b0;
      phi2       <= 1'b0;
      resb_n     <= 1'b0;
      stretching <= 1'b0;
      phi2_fall  <= 1'b0;
    end else begin
      phi2_fall <= 1'b0;

      // Steps are only accepted in LOW, so a step arriving during the pulse it
      // requested is dropped rather than queuing a second pulse.
      if (step && !run && state == S_LOW)
        step_pend <= 1'b1;

      case (state)
        S_LOW: begin
          if (cnt == LOW_END) begin
            if (run || step_pend) begin
              state     <= S_HIGH;
              cnt       <= '0;
              phi2      <= 1'b1;
              step_pend <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HIGH: begin
          if (cnt == HIGH_END) begin
            cnt <= '0;
            if (!slow_sel_n) begin
              state      <= S_STRETCH;
              stretching <= 1'b1;
            end else begin
              state     <= S_LOW;
              phi2      <= 1'b0;
              phi2_fall <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_STRETCH: begin
          if (cnt == STR_END) begin
            state      <= S_LOW;
            cnt        <= '0;
            phi2       <= 1'b0;
            stretching <= 1'b0;
            phi2_fall  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state      <= S_LOW;
          cnt        <= '0;
          phi2       <= 1'b0;
          stretching <= 1'b0;
        end
      endcase

      if (fall_now && rcnt != RST_END) begin
        rcnt <= rcnt + 8'd1;
        if (rcnt == RST_END - 8'd1)
          resb_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_herring_phi2_gen.sv
// Scoreboard bench for herring_phi2_gen: expected PHI2 pulses are queued by the
// stimulus and checked by a monitor that measures each pulse as it completes.
module tb_herring_phi2_gen;

  localparam int LOW     = 25;
  localparam int HIGH    = 25;
  localparam int STRETCH = 50;
  localparam int RCYC    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slow_sel_n = 1'b1;
  logic run = 1'b1;
  logic step = 1'b0;
  logic phi2, resb_n, stretching, phi2_fall;
  logic f_phi2, f_resb, f_str, f_fall;

  always #10 clk = ~clk;

  herring_phi2_gen dut (
    .clk_src(clk), .rst(rst), .slow_sel_n(slow_sel_n), .run(run), .step(step),
    .phi2(phi2), .resb_n(resb_n), .stretching(stretching), .phi2_fall(phi2_fall)
  );

  herring_phi2_gen #(.LOW_TICKS(1), .HIGH_TICKS(1), .STRETCH_TICKS(1), .RESET_CYCLES(4)) fast (
    .clk_src(clk), .rst(rst), .slow_sel_n(1'b0), .run(1'b1), .step(1'b0),
    .phi2(f_phi2), .resb_n(f_resb), .stretching(f_str), .phi2_fall(f_fall)
  );

  typedef struct {
    int low;
    int high;
    int str;
  } pulse_t;

  pulse_t q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Expected pulse shape; low < 0 means the preceding low time is not defined (parked).
  function automatic pulse_t model(input int low, input bit slow);
    pulse_t p;
    p.low  = low;
    p.str  = slow ? STRETCH : 0;
    p.high = HIGH + p.str;
    return p;
  endfunction

  // Main monitor: measures low/high/stretch lengths per pulse and tracks resb_n.
  int   lo, hi, st, meas_lo, falls;
  logic prev;
  always @(negedge clk) begin
    if (rst) begin
      lo = 0; hi = 0; st = 0; meas_lo = 0; falls = 0; prev = 1'b0;
    end else begin
      check("phi2_fall", phi2_fall, prev && !phi2);
      if (phi2 && !prev) begin
        meas_lo = lo;
        hi = 0;
        st = 0;
      end
      if (!phi2 && prev) begin
        pulse_t e;
        falls++;
        check("pulse_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("high_len", hi, e.high);
          check("stretch_len", st, e.str);
          if (e.low >= 0) check("low_len", meas_lo, e.low);
        end
        lo = 0;
      end
      if (phi2) begin
        hi++;
        if (stretching) st++;
      end else begin
        lo++;
        check("stretch_while_low", stretching, 0);
      end
      check("resb_n", resb_n, falls >= RCYC);
      prev = phi2;
    end
  end

  // Monitor for the 1/1/1 instance: period 3, high 2, stretch 1, one strobe per fall.
  int   cyc, f_last, f_hi, f_st;
  bit   f_seen;
  logic f_prev;
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; f_last = 0; f_hi = 0; f_st = 0; f_seen = 1'b0; f_prev = 1'b0;
    end else begin
      cyc++;
      check("fast_fall_strobe", f_fall, f_prev && !f_phi2);
      if (f_phi2) begin
        f_hi++;
        if (f_str) f_st++;
      end
      if (f_prev && !f_phi2) begin
        if (f_seen) check("fast_period", cyc - f_last, 3);
        check("fast_high", f_hi, 2);
        check("fast_stretch", f_st, 1);
        f_seen = 1'b1;
        f_last = cyc;
        f_hi = 0;
        f_st = 0;
      end
      f_prev = f_phi2;
    end
  end

  task automatic wait_phi2(input logic v, input int budget, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (phi2 !== v && n < budget);
    if (phi2 !== v) check(nm, int'(phi2), int'(v));
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (q.size() != 0 && n < budget);
    check("queue_drain", q.size(), 0);
  endtask

  task automatic pulse_step();
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_phi2", phi2, 0);
    check("rst_resb_n", resb_n, 0);
    check("rst_stretching", stretching, 0);
    check("rst_phi2_fall", phi2_fall, 0);
    for (int i = 0; i < 6; i++) q.push_back(model(LOW, 1'b0));
    rst = 1'b0;
    wait_empty(600);

    // Free run with a random slow-device decision per pulse
    for (int i = 0; i < 12; i++) begin
      wait_phi2(1'b0, 200, "fall_timeout");
      wait_phi2(1'b1, 200, "rise_timeout");
      s = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      slow_sel_n = !s;
      q.push_back(model(LOW, s));
    end
    wait_empty(300);
    slow_sel_n = 1'b1;

    // Step with run=1 is ignored; dropping run in LOW parks without another pulse
    repeat (3) @(negedge clk);
    pulse_step();
    repeat (3) @(negedge clk);
    run = 1'b0;
    repeat (200) @(negedge clk);
    check("parked_phi2", phi2, 0);
    wait_empty(5);

    // Single steps; even iterations issue a second step 3 clk after the first
    for (int k = 0; k < 4; k++) begin
      s = 1'($urandom_range(0, 1));
      slow_sel_n = !s;
      q.push_back(model(-1, s));
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      if (k % 2 == 0) begin
        repeat (1) @(negedge clk);
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
      end
      repeat (150) @(negedge clk);
      wait_empty(5);
    end

    // run drops mid-HIGH: that cycle completes, then parks
    s = 1'($urandom_range(0, 1));
    slow_sel_n = !s;
    q.push_back(model(-1, s));
    run = 1'b1;
    wait_phi2(1'b1, 50, "run_rise_timeout");
    run = 1'b0;
    repeat (200) @(negedge clk);
    wait_empty(5);

    // Reset asserted during STRETCH
    slow_sel_n = 1'b0;
    run = 1'b1;
    n = 0;
    while (!stretching && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("stretch_seen", stretching, 1);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_phi2", phi2, 0);
    check("midrst_resb_n", resb_n, 0);
    check("midrst_stretching", stretching, 0);
    check("midrst_fast_phi2", f_phi2, 0);
    q.delete();
    slow_sel_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 6; i++) q.push_back(model(LOW, 1'b0));
    rst = 1'b0;
    wait_empty(600);
    check("final_resb_n", resb_n, 1);
    check("final_fast_resb", f_resb, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
